// File: rtl/alu_pkg.sv
// Shared ALU opcodes and driver FSM state encoding.
// No ports; imported by the driver and its bench.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command stream, ALU operand bus and response stream of the driver.
// master: the driver block; slave: command source, ALU and consumer.
interface alu_cmd_driver_if #(
  parameter int WIDTH = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [1:0]       cmd_sel;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic [1:0]       rsp_sel;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel,
    output cmd_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_result, alu_carry,
    output rsp_valid, rsp_result, rsp_carry, rsp_sel,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_sel,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_result, alu_carry,
    input  rsp_valid, rsp_result, rsp_carry, rsp_sel,
    output rsp_ready
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, no bypass; extra pointer MSB tells full from empty.
// Ports: clk, rst, push_i/din_i, pop_i/dout_o, full_o, empty_o.
module alu_cmd_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// ALU initiator: queues commands, drives ALU, waits SETTLE, returns results.
// Ports: clk, rst, bus (master), busy, op_count.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_cmd_driver_if.master     bus,
  output logic                 busy,
  output logic [7:0]           op_count
);

  localparam int DW = 2 * WIDTH + 2;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    settle_q, settle_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_sel_q, alu_sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [1:0]       rsp_sel_q, rsp_sel_d;
  logic [7:0]       op_count_q, op_count_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             cmd_push;
  logic [DW-1:0]    fifo_dout;
  logic             logic_op;

  // Held low during reset so nothing is offered as accepted.
  assign bus.cmd_ready = !fifo_full && !rst;
  assign cmd_push      = bus.cmd_valid && bus.cmd_ready;

  alu_cmd_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_push),
    .din_i   ({bus.cmd_sel, bus.cmd_a, bus.cmd_b}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The ALU leaves carry undriven for logic ops.
  assign logic_op = (alu_sel_q == ALU_AND) || (alu_sel_q == ALU_OR);

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_sel_d    = rsp_sel_q;
    op_count_d   = op_count_q;
    fifo_pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          {alu_sel_d, alu_a_d, alu_b_d} = fifo_dout;
          settle_d = CW'(SETTLE - 1);
          state_d  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (settle_q == '0) begin
          rsp_result_d = bus.alu_result;
          rsp_carry_d  = logic_op ? 1'b0 : bus.alu_carry;
          rsp_sel_d    = alu_sel_q;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else begin
          settle_d = settle_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_sel_q    <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_sel_q    <= rsp_sel_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_sel    = rsp_sel_q;
  assign op_count       = op_count_q;
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: 4-bit ALU model on the operand bus,
// scoreboard of expected responses filled as commands are accepted.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic [3:0] res;
    logic       c;
    logic [1:0] sel;
    logic [3:0] a;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [7:0]  op_count;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_ops = 0;
  int unsigned cyc = 0;
  exp_t        sbq[$];

  alu_cmd_driver_if #(.WIDTH(W)) bus ();

  alu_cmd_driver #(
    .WIDTH      (W),
    .FIFO_DEPTH (4),
    .SETTLE     (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ALU: carry is not driven for logic ops; modelled as a stray 1.
  always_comb begin
    logic [W:0] t;
    t = '0;
    case (bus.alu_sel)
      ALU_ADD: t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      ALU_SUB: t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      ALU_AND: t = {1'b1, bus.alu_a & bus.alu_b};
      default: t = {1'b1, bus.alu_a | bus.alu_b};
    endcase
    bus.alu_result = t[W-1:0];
    bus.alu_carry  = t[W];
  end

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b,
                                 input logic [1:0] s);
    exp_t e;
    logic [4:0] t;
    case (s)
      2'b00:   t = {1'b0, a} + {1'b0, b};
      2'b01:   t = {1'b0, a} - {1'b0, b};
      2'b10:   t = {1'b0, a & b};
      default: t = {1'b0, a | b};
    endcase
    e.res = t[3:0];
    e.c   = t[4];
    e.sel = s;
    e.a   = a;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] s);
    int w;
    bit done;
    w = 0;
    done = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = s;
    while (!done && w < 60) begin
      if (bus.cmd_ready === 1'b1) begin
        sbq.push_back(model(a, b, s));
        done = 1;
      end
      tick();
      w++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_sel = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({bus.cmd_ready, bus.rsp_valid, busy, op_count} !== 11'h0) begin
      n_bad++;
      $display("FAIL reset_hold: rdy/val/busy/cnt=%b%b%b/%h required 0",
               bus.cmd_ready, bus.rsp_valid, busy, op_count);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b required 1", bus.cmd_ready);
    end
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_sel,
         bus.alu_a, bus.alu_b, bus.alu_sel, busy, op_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rsp_valid=%b alu_a=%h busy=%b cnt=%h required 0",
               bus.rsp_valid, bus.alu_a, busy, op_count);
    end
  endtask

  task automatic test_latency();
    exp_t e;
    push_cmd(4'h9, 4'h8, ALU_ADD);
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL lat_c1: rsp_valid=%b busy=%b required 0/1", bus.rsp_valid, busy);
    end
    tick();
    n_cmp++;
    if ({bus.alu_a, bus.alu_b, bus.alu_sel, bus.rsp_valid} !== {4'h9, 4'h8, 2'b00, 1'b0}) begin
      n_bad++;
      $display("FAIL lat_c2: a=%h b=%h sel=%b v=%b required 9/8/00/0",
               bus.alu_a, bus.alu_b, bus.alu_sel, bus.rsp_valid);
    end
    tick();
    e = sbq.pop_front();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_sel} !==
        {1'b1, 4'h1, 1'b1, 2'b00} || {e.res, e.c} !== {4'h1, 1'b1}) begin
      n_bad++;
      $display("FAIL lat_c3: v=%b res=%h c=%b sel=%b required 1/1/1/00",
               bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_sel);
    end
    bus.rsp_ready = 1'b1;
    tick();
    exp_ops++;
    bus.rsp_ready = 1'b0;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || op_count !== 8'd1) begin
      n_bad++;
      $display("FAIL lat_done: v=%b cnt=%0d required 0/1", bus.rsp_valid, op_count);
    end
  endtask

  task automatic test_sub();
    exp_t e;
    bus.rsp_ready = 1'b0;
    push_cmd(4'h3, 4'h5, ALU_SUB);
    push_cmd(4'h5, 4'h3, ALU_SUB);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      int w;
      w = 0;
      while (bus.rsp_valid !== 1'b1 && w < 40) begin tick(); w++; end
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || sbq.size() == 0) begin
        n_bad++;
        $display("FAIL sub_rsp%0d: rsp_valid=%b required 1", k, bus.rsp_valid);
      end else begin
        e = sbq.pop_front();
        exp_ops++;
        if ({bus.rsp_result, bus.rsp_carry, bus.rsp_sel} !== {e.res, e.c, e.sel}) begin
          n_bad++;
          $display("FAIL sub_rsp%0d: got %h/%b/%b required %h/%b/%b", k,
                   bus.rsp_result, bus.rsp_carry, bus.rsp_sel, e.res, e.c, e.sel);
        end
      end
      tick();
    end
    bus.rsp_ready = 1'b0;
    n_cmp++;
    if (op_count !== 8'(exp_ops)) begin
      n_bad++;
      $display("FAIL sub_count: got %0d required %0d", op_count, exp_ops);
    end
  endtask

  task automatic test_logic_mask();
    exp_t e;
    bus.rsp_ready = 1'b0;
    push_cmd(4'hF, 4'h1, ALU_ADD);
    push_cmd(4'hC, 4'hA, ALU_AND);
    push_cmd(4'h5, 4'h2, ALU_OR);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int w;
      w = 0;
      while (bus.rsp_valid !== 1'b1 && w < 40) begin tick(); w++; end
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || sbq.size() == 0) begin
        n_bad++;
        $display("FAIL mask_rsp%0d: rsp_valid=%b required 1", k, bus.rsp_valid);
      end else begin
        e = sbq.pop_front();
        exp_ops++;
        if ({bus.rsp_result, bus.rsp_carry, bus.rsp_sel} !== {e.res, e.c, e.sel}) begin
          n_bad++;
          $display("FAIL mask_rsp%0d: got %h/%b/%b required %h/%b/%b", k,
                   bus.rsp_result, bus.rsp_carry, bus.rsp_sel, e.res, e.c, e.sel);
        end
      end
      tick();
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    bus.rsp_ready = 1'b0;
    push_cmd(4'h1, 4'h2, ALU_ADD);
    push_cmd(4'h7, 4'h9, ALU_SUB);
    push_cmd(4'h6, 4'h3, ALU_AND);
    push_cmd(4'h8, 4'h1, ALU_OR);
    push_cmd(4'hE, 4'hE, ALU_ADD);
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 4'hA;
    bus.cmd_b = 4'hB;
    bus.cmd_sel = ALU_OR;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.cmd_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL full_ready%0d: got %b required 0", i, bus.cmd_ready);
      end
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry} !== {1'b1, sbq[0].res, sbq[0].c}) begin
        n_bad++;
        $display("FAIL held_rsp%0d: got %b/%h/%b required 1/%h/%b", i,
                 bus.rsp_valid, bus.rsp_result, bus.rsp_carry, sbq[0].res, sbq[0].c);
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int w;
      w = 0;
      while (bus.rsp_valid !== 1'b1 && w < 40) begin tick(); w++; end
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || sbq.size() == 0) begin
        n_bad++;
        $display("FAIL drain_rsp%0d: rsp_valid=%b required 1", k, bus.rsp_valid);
      end else begin
        e = sbq.pop_front();
        exp_ops++;
        if ({bus.rsp_result, bus.rsp_carry, bus.rsp_sel} !== {e.res, e.c, e.sel}) begin
          n_bad++;
          $display("FAIL drain_rsp%0d: got %h/%b/%b required %h/%b/%b", k,
                   bus.rsp_result, bus.rsp_carry, bus.rsp_sel, e.res, e.c, e.sel);
        end
      end
      tick();
    end
    repeat (6) tick();
    n_cmp++;
    if ({bus.rsp_valid, busy} !== 2'b00 || op_count !== 8'(exp_ops)) begin
      n_bad++;
      $display("FAIL drain_idle: v=%b busy=%b cnt=%0d required 0/0/%0d",
               bus.rsp_valid, busy, op_count, exp_ops);
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    bit seen;
    int w;
    bus.rsp_ready = 1'b0;
    push_cmd(4'h4, 4'h4, ALU_ADD);
    push_cmd(4'h6, 4'h2, ALU_SUB);
    push_cmd(4'h3, 4'h3, ALU_AND);
    push_cmd(4'h2, 4'h1, ALU_OR);
    w = 0;
    while (bus.rsp_valid !== 1'b1 && w < 40) begin tick(); w++; end
    e = sbq.pop_front();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry} !== {1'b1, e.res, e.c}) begin
      n_bad++;
      $display("FAIL rst_first: got %b/%h/%b required 1/%h/%b",
               bus.rsp_valid, bus.rsp_result, bus.rsp_carry, e.res, e.c);
    end
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.alu_a !== sbq[0].a || busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_drive: alu_a=%h busy=%b v=%b required %h/1/0",
               bus.alu_a, busy, bus.rsp_valid, sbq[0].a);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_sel, bus.alu_a,
         bus.alu_b, bus.alu_sel, bus.cmd_ready, busy, op_count} !== '0) begin
      n_bad++;
      $display("FAIL rst_outputs: v=%b a=%h rdy=%b busy=%b cnt=%h required 0",
               bus.rsp_valid, bus.alu_a, bus.cmd_ready, busy, op_count);
    end
    rst = 1'b0;
    sbq.delete();
    exp_ops = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    n_cmp++;
    if (seen || bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_dropped: stray activity=%b rdy=%b required 0/1", seen, bus.cmd_ready);
    end
    push_cmd(4'h2, 4'h3, ALU_ADD);
    w = 0;
    while (bus.rsp_valid !== 1'b1 && w < 40) begin tick(); w++; end
    e = sbq.pop_front();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_sel} !==
        {1'b1, e.res, e.c, e.sel}) begin
      n_bad++;
      $display("FAIL rst_after: got %b/%h/%b required 1/%h/%b",
               bus.rsp_valid, bus.rsp_result, bus.rsp_carry, e.res, e.c);
    end
    tick();
    exp_ops++;
    n_cmp++;
    if (op_count !== 8'(exp_ops)) begin
      n_bad++;
      $display("FAIL rst_count: got %0d required %0d", op_count, exp_ops);
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    sbq.delete();
    exp_ops = 0;
    bus.rsp_ready = 1'b1;
    tick();
    fork
      begin
        for (int i = 0; i < 256; i++)
          push_cmd(4'($urandom), 4'($urandom), 2'($urandom));
      end
      begin
        exp_t e;
        int unsigned last;
        last = 0;
        for (int k = 0; k < 256; k++) begin
          int w;
          w = 0;
          while (bus.rsp_valid !== 1'b1 && w < 40) begin tick(); w++; end
          n_cmp++;
          if (bus.rsp_valid !== 1'b1 || sbq.size() == 0) begin
            n_bad++;
            $display("FAIL b2b_rsp%0d: rsp_valid=%b required 1", k, bus.rsp_valid);
          end else begin
            e = sbq.pop_front();
            if ({bus.rsp_result, bus.rsp_carry, bus.rsp_sel, op_count} !==
                {e.res, e.c, e.sel, 8'(exp_ops)}) begin
              n_bad++;
              $display("FAIL b2b_rsp%0d: got %h/%b/%b cnt=%0d required %h/%b/%b cnt=%0d",
                       k, bus.rsp_result, bus.rsp_carry, bus.rsp_sel, op_count,
                       e.res, e.c, e.sel, 8'(exp_ops));
            end
            exp_ops++;
            if (k > 0) begin
              n_cmp++;
              if (cyc - last !== 3) begin
                n_bad++;
                $display("FAIL b2b_gap%0d: got %0d cycles required 3", k, cyc - last);
              end
            end
            last = cyc;
          end
          tick();
        end
      end
    join
    n_cmp++;
    if (op_count !== 8'd0 || exp_ops != 256) begin
      n_bad++;
      $display("FAIL b2b_wrap: cnt=%0d ops=%0d required 0/256", op_count, exp_ops);
    end
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sub();
    test_logic_mask();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
